uart_tx_byte: RTL and testbench



---
 rtl/uart_tx_byte.sv | 123 ++++++++++++
 tb/tb_uart_tx_byte.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1/8N2 UART transmitter with ready/accepted byte handshake
// Bytes are taken only in IDLE; tx is a registered output, so it has no input-to-pin path.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_data_ready,
    input  logic [7:0] tx_data,
    output logic       tx_data_accepted,
    output logic       tx,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        stop_q, stop_d;
    logic        tx_q, tx_d;
    logic        acc_q, acc_d;
    logic        bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        acc_d   = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        end

        // tx_d always carries the level for the next cycle, so transitions look one bit ahead.
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = 16'd0;
                if (tx_data_ready) begin
                    shift_d = tx_data;
                    acc_d   = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            acc_q   <= acc_d;
        end
    end

    assign tx               = tx_q;
    assign tx_data_accepted = acc_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_byte.sv
// tb/tb_uart_tx_byte.sv - directed/random bench for uart_tx_byte against a frame model
module tb_uart_tx_byte;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready1 = 1'b0, ready2 = 1'b0;
    logic [7:0] data1 = 8'h00, data2 = 8'h00;
    logic       acc1, tx1, busy1;
    logic       acc2, tx2, busy2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    logic dec_en = 1'b0;
    logic dec_last = 1'b1;
    logic [7:0] dec_b;
    logic [7:0] dec_q[$];
    int starts[$];

    uart_tx_byte #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data_ready(ready1), .tx_data(data1),
        .tx_data_accepted(acc1), .tx(tx1), .busy(busy1)
    );

    uart_tx_byte #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data_ready(ready2), .tx_data(data2),
        .tx_data_accepted(acc2), .tx(tx2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (acc1 === 1'b1) acc_cnt <= acc_cnt + 1;

    // Independent line decoder: samples each bit at its centre after a falling start edge.
    initial begin
        forever begin
            @(negedge clk);
            if (dec_en && dec_last === 1'b1 && tx1 === 1'b0) begin
                starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    dec_b[i] = tx1;
                end
                repeat (CPB) @(negedge clk);
                dec_q.push_back(dec_b);
            end
            dec_last = tx1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? tx1 : tx2;
    endfunction

    function automatic logic acc_of(input int sel);
        return (sel == 0) ? acc1 : acc2;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy1 : busy2;
    endfunction

    // Line level t cycles after the start bit begins: start, 8 data LSB first, then stop.
    function automatic logic exp_bit(input logic [7:0] b, input int t);
        if (t < CPB) return 1'b0;
        if (t < 9 * CPB) return b[t / CPB - 1];
        return 1'b1;
    endfunction

    task automatic start_frame(input int sel, input logic [7:0] b);
        int n;
        n = 0;
        if (sel == 0) begin ready1 = 1'b1; data1 = b; end
        else begin ready2 = 1'b1; data2 = b; end
        tick();
        while (acc_of(sel) !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("accept_pulse", acc_of(sel), 1);
        check("start_bit", tx_of(sel), 0);
        check("busy_start", busy_of(sel), 1);
        if (sel == 0) ready1 = 1'b0;
        else ready2 = 1'b0;
    endtask

    task automatic body(input int sel, input logic [7:0] b, input int t0, input int t1,
                        input bit toggle);
        for (int t = t0; t <= t1; t++) begin
            check("frame_tx", tx_of(sel), exp_bit(b, t));
            check("frame_busy", busy_of(sel), 1);
            if (t > 0) check("single_pulse", acc_of(sel), 0);
            if (toggle) begin
                if (sel == 0) data1 = 8'($urandom);
                else data2 = 8'($urandom);
            end
            tick();
        end
    endtask

    task automatic idle_check(input int sel);
        check("idle_busy", busy_of(sel), 0);
        check("idle_tx", tx_of(sel), 1);
        check("idle_acc", acc_of(sel), 0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] msg[4];
        int t0, n, acc_base;
        msg[0] = 8'h45; msg[1] = 8'h03; msg[2] = 8'h0D; msg[3] = 8'h0A;

        // Reset held with a byte waiting: nothing may leave the block.
        repeat (2) tick();
        ready1 = 1'b1;
        data1  = 8'h55;
        repeat (3) begin
            tick();
            check("rst_tx", tx1, 1);
            check("rst_acc", acc1, 0);
            check("rst_busy", busy1, 0);
        end
        rst = 1'b0;
        start_frame(0, 8'h55);
        body(0, 8'h55, 0, 39, 1);
        idle_check(0);

        // Single byte 0xA5, frame of 40 cycles then busy falls.
        start_frame(0, 8'hA5);
        t0 = cyc;
        body(0, 8'hA5, 0, 39, 1);
        idle_check(0);
        check("busy_fall_cycles", cyc - t0, 40);

        // Random bytes with random idle gaps.
        repeat (6) begin
            b = 8'($urandom);
            start_frame(0, b);
            body(0, b, 0, 39, 1);
            idle_check(0);
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("idle_hold_tx", tx1, 1);
            end
        end

        // Back-to-back producer that waits to see busy low before offering the next byte.
        dec_q.delete();
        starts.delete();
        acc_base = acc_cnt;
        dec_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (busy1 !== 1'b0 && n < 100) begin tick(); n++; end
            tick();
            ready1 = 1'b1;
            data1  = msg[k];
            n = 0;
            tick();
            while (acc1 !== 1'b1 && n < 100) begin tick(); n++; end
            check("b2b_accept", acc1, 1);
            ready1 = 1'b0;
        end
        n = 0;
        while (busy1 !== 1'b0 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        dec_en = 1'b0;
        check("b2b_count", dec_q.size(), 4);
        check("b2b_pulses", acc_cnt - acc_base, 4);
        for (int k = 0; k < 4 && k < dec_q.size(); k++)
            check("b2b_byte", dec_q[k], msg[k]);
        for (int k = 1; k < starts.size(); k++)
            check("b2b_spacing", starts[k] - starts[k-1], 42);

        // Two stop bits: 4 low, 40 high, busy 44 cycles.
        start_frame(1, 8'hFF);
        t0 = cyc;
        body(1, 8'hFF, 0, 43, 0);
        idle_check(1);
        check("stop2_busy_cycles", cyc - t0, 44);

        // Reset during data bit 3, with the next byte already pending.
        start_frame(0, 8'h00);
        body(0, 8'h00, 0, 16, 1);
        rst    = 1'b1;
        ready1 = 1'b1;
        data1  = 8'h81;
        tick();
        check("midrst_tx", tx1, 1);
        check("midrst_busy", busy1, 0);
        check("midrst_acc", acc1, 0);
        rst = 1'b0;
        start_frame(0, 8'h81);
        body(0, 8'h81, 0, 39, 1);
        idle_check(0);

        // Ready raised during the stop bit: held off until IDLE, frame in flight unchanged.
        start_frame(0, 8'h3C);
        body(0, 8'h3C, 0, 37, 1);
        ready1 = 1'b1;
        data1  = 8'h12;
        body(0, 8'h3C, 38, 39, 0);
        check("held_acc", acc1, 0);
        check("held_busy", busy1, 0);
        start_frame(0, 8'h12);
        body(0, 8'h12, 0, 39, 1);
        idle_check(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
